// File: rtl/baud_ctrl_if.sv
// Configuration channel of baud_ctrl: divisor offer/accept handshake plus the illegal-divisor pulse.
interface baud_ctrl_if #(
    parameter int DIV_WIDTH = 16
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [DIV_WIDTH-1:0] cfg_div;
    logic [3:0]           cfg_frac;
    logic                 cfg_err;

    modport master (
        output cfg_valid, cfg_div, cfg_frac,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_frac,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/baud_ctrl.sv
// Baud tick scheduler: owns the divisor, emits 16x/1x ticks, defers rate changes to bit boundaries.
// Optional fractional divisor enabled by defining BAUD_CTRL_FRAC_EN.
module baud_ctrl #(
    parameter int          DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 78
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 tx_en,
    input  logic                 rx_en,
    input  logic                 rx_restart,
    baud_ctrl_if.slave           cfg,
    output logic [DIV_WIDTH-1:0] active_div,
    output logic                 tick16,
    output logic                 tick1
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN   = DIV_WIDTH'(2);

    logic [1:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] active_q, active_d;
    logic [DIV_WIDTH-1:0] pend_q, pend_d;
    logic [3:0]           phase_q, phase_d;
    logic [3:0]           frac_q, frac_d;
    logic [3:0]           pfrac_q, pfrac_d;
    logic [3:0]           acc_q, acc_d;
    logic                 tick16_q, tick16_d;
    logic                 tick1_q, tick1_d;
    logic                 err_q, err_d;
    logic                 ready_q, ready_d;

    logic                 run;
    logic                 xfer;
    logic                 take;
    logic                 cnt_zero;
    logic                 bit_end;
    logic [3:0]           frac_in;
    logic [4:0]           acc_sum;

`ifdef BAUD_CTRL_FRAC_EN
    assign frac_in = cfg.cfg_frac;
`else
    // Without the fractional feature the accumulator sees a constant zero and folds away.
    logic frac_unused;
    assign frac_in     = 4'd0;
    assign frac_unused = ^cfg.cfg_frac;
`endif

    assign run      = tx_en | rx_en;
    assign xfer     = cfg.cfg_valid & ready_q;
    assign take     = xfer & (cfg.cfg_div >= DIV_MIN);
    assign cnt_zero = (cnt_q == '0);
    assign bit_end  = cnt_zero & (phase_q == 4'd15);
    assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        active_d = active_q;
        pend_d   = pend_q;
        frac_d   = frac_q;
        pfrac_d  = pfrac_q;
        acc_d    = acc_q;
        tick16_d = 1'b0;
        tick1_d  = 1'b0;
        err_d    = xfer & ~take;

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                phase_d = '0;
                acc_d   = '0;
                if (take) begin
                    active_d = cfg.cfg_div;
                    frac_d   = frac_in;
                end
                if (run) begin
                    state_d = ST_RUN;
                    cnt_d   = active_d - DIV_ONE;
                end
            end

            ST_RUN, ST_PEND: begin
                if (!run) begin
                    // Stopping never strands a change: a pending or same-cycle divisor lands now.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    phase_d = '0;
                    acc_d   = '0;
                    if (state_q == ST_PEND) begin
                        active_d = pend_q;
                        frac_d   = pfrac_q;
                    end else if (take) begin
                        active_d = cfg.cfg_div;
                        frac_d   = frac_in;
                    end
                end else begin
                    if (rx_restart) begin
                        phase_d = 4'd8;
                        acc_d   = '0;
                        if (state_q == ST_PEND) begin
                            active_d = pend_q;
                            frac_d   = pfrac_q;
                            state_d  = ST_RUN;
                        end
                        cnt_d = active_d - DIV_ONE;
                    end else if (cnt_zero) begin
                        tick16_d = 1'b1;
                        tick1_d  = (phase_q == 4'd15);
                        phase_d  = phase_q + 4'd1;
                        if (bit_end && (state_q == ST_PEND)) begin
                            active_d = pend_q;
                            frac_d   = pfrac_q;
                            acc_d    = '0;
                            state_d  = ST_RUN;
                            cnt_d    = pend_q - DIV_ONE;
                        end else begin
                            // A carry out of the sixteenths accumulator stretches the next period by one.
                            acc_d = acc_sum[3:0];
                            cnt_d = acc_sum[4] ? active_q : (active_q - DIV_ONE);
                        end
                    end else begin
                        cnt_d = cnt_q - DIV_ONE;
                    end

                    if (take) begin
                        pend_d  = cfg.cfg_div;
                        pfrac_d = frac_in;
                        state_d = ST_PEND;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                phase_d = '0;
                acc_d   = '0;
            end
        endcase

        ready_d = (state_d != ST_PEND);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            phase_q  <= '0;
            active_q <= DIV_RESET;
            pend_q   <= DIV_RESET;
            frac_q   <= '0;
            pfrac_q  <= '0;
            acc_q    <= '0;
            tick16_q <= 1'b0;
            tick1_q  <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            frac_q   <= frac_d;
            pfrac_q  <= pfrac_d;
            acc_q    <= acc_d;
            tick16_q <= tick16_d;
            tick1_q  <= tick1_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    assign active_div    = active_q;
    assign tick16        = tick16_q;
    assign tick1         = tick1_q;
    assign cfg.cfg_err   = err_q;
    assign cfg.cfg_ready = ready_q;

endmodule

// File: tb/tb_baud_ctrl.sv
// Self-checking bench for baud_ctrl: directed vector table, corner-case sequences and a
// randomized run against a tick-schedule reference model.
module tb_baud_ctrl;
    localparam int DW = 16;
`ifdef BAUD_CTRL_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_en = 1'b0;
    logic          rx_en = 1'b0;
    logic          rx_restart = 1'b0;
    logic [DW-1:0] active_div;
    logic          tick16;
    logic          tick1;

    always #5 clk_in = ~clk_in;

    baud_ctrl_if #(.DIV_WIDTH(DW)) cfg_bus ();

    baud_ctrl #(.DIV_WIDTH(DW), .DEFAULT_DIV(78)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .rx_en      (rx_en),
        .rx_restart (rx_restart),
        .cfg        (cfg_bus.slave),
        .active_div (active_div),
        .tick16     (tick16),
        .tick1      (tick1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t16_q[$];
    int t1_q[$];
    bit last_xfer;

    // Reference model: absolute cycle of the next tick16 and tick16s left until the bit tick.
    int m_mode = 0;            // 0 idle, 1 running, 2 running with a change pending
    int m_act = 78, m_pdiv = 78, m_afrac = 0, m_pfrac = 0;
    int m_next = 0, m_left = 16, m_k = 0;
    bit m_ready = 1'b1;
    bit e_t16, e_t1, e_err;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Carries of a sixteenths accumulator: the k-th tick since clearing carries when floor(k*f/16) steps.
    function automatic int frac_extra(int k, int f);
        return (k * f) / 16 - ((k - 1) * f) / 16;
    endfunction

    task automatic step();
        bit c_rst, c_run, c_rs, c_v, take;
        int c_div, c_frac;
        c_rst  = rst_n;
        c_run  = tx_en | rx_en;
        c_rs   = rx_restart;
        c_v    = cfg_bus.cfg_valid;
        c_div  = int'(cfg_bus.cfg_div);
        c_frac = FRAC_ON ? int'(cfg_bus.cfg_frac) : 0;
        @(posedge clk_in);
        #1;
        cyc++;
        last_xfer = c_v && m_ready;
        e_t16 = 0; e_t1 = 0; e_err = 0;
        if (!c_rst) begin
            m_mode = 0; m_act = 78; m_pdiv = 78; m_afrac = 0; m_pfrac = 0;
            last_xfer = 0;
        end else begin
            take  = last_xfer && (c_div >= 2);
            e_err = last_xfer && (c_div < 2);
            if (m_mode == 0) begin
                if (take) begin m_act = c_div; m_afrac = c_frac; end
                if (c_run) begin m_mode = 1; m_next = cyc + m_act; m_left = 16; m_k = 0; end
            end else if (!c_run) begin
                if (m_mode == 2) begin m_act = m_pdiv; m_afrac = m_pfrac; end
                else if (take) begin m_act = c_div; m_afrac = c_frac; end
                m_mode = 0;
            end else begin
                if (c_rs) begin
                    if (m_mode == 2) begin m_act = m_pdiv; m_afrac = m_pfrac; m_mode = 1; end
                    m_next = cyc + m_act; m_left = 8; m_k = 0;
                end else if (cyc == m_next) begin
                    e_t16 = 1; m_k++; m_left--;
                    if (m_left == 0) begin e_t1 = 1; m_left = 16; end
                    if (e_t1 && m_mode == 2) begin
                        m_act = m_pdiv; m_afrac = m_pfrac; m_mode = 1; m_k = 0;
                        m_next = cyc + m_act;
                    end else begin
                        m_next = cyc + m_act + frac_extra(m_k, m_afrac);
                    end
                end
                if (take) begin m_pdiv = c_div; m_pfrac = c_frac; m_mode = 2; end
            end
        end
        m_ready = (m_mode != 2);
        check("tick16", 32'(tick16), 32'(e_t16));
        check("tick1", 32'(tick1), 32'(e_t1));
        check("cfg_err", 32'(cfg_bus.cfg_err), 32'(e_err));
        check("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(m_ready));
        check("active_div", 32'(active_div), 32'(m_act));
        if (tick16 === 1'b1) t16_q.push_back(cyc);
        if (tick1 === 1'b1) t1_q.push_back(cyc);
    endtask

    task automatic do_reset();
        rst_n = 0; tx_en = 0; rx_en = 0; rx_restart = 0; cfg_bus.cfg_valid = 0;
        step(); step();
        rst_n = 1;
    endtask

    task automatic cfg_send(input int div, input int frac, output bit err_seen);
        int n;
        n = 0;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = DW'(div);
        cfg_bus.cfg_frac  = 4'(frac);
        do begin step(); n++; end while (!last_xfer && n < 3000);
        check("cfg_xfer_done", 32'(last_xfer), 32'd1);
        err_seen = cfg_bus.cfg_err;
        cfg_bus.cfg_valid = 1'b0;
        $display("cfg xfer div=%0d frac=%0d err=%0b active=%0d cycle=%0d",
                 div, frac, err_seen, active_div, cyc);
    endtask

    task automatic run_until(input int n16, input int n1, input int bound);
        int n;
        n = 0;
        while ((t16_q.size() < n16 || t1_q.size() < n1) && n < bound) begin step(); n++; end
        check("wait_bound", 32'(n < bound), 32'd1);
    endtask

    typedef struct {
        bit send;  int div;   bit use_rx;
        bit exp_err; int exp_act; int exp_first; int exp_p16; int exp_p1;
    } vec_t;

    initial begin
        vec_t vecs[6];
        bit err_seen;
        int c0, tr, t, errs;

        vecs[0] = '{0, 0, 0, 0, 78, 78, 78, 1248};
        vecs[1] = '{1, 4, 1, 0,  4,  4,  4,   64};
        vecs[2] = '{1, 2, 0, 0,  2,  2,  2,   32};
        vecs[3] = '{1, 9, 1, 0,  9,  9,  9,  144};
        vecs[4] = '{1, 1, 0, 1, 78, 78, 78, 1248};
        vecs[5] = '{1, 0, 1, 1, 78, 78, 78, 1248};
        cfg_bus.cfg_valid = 0; cfg_bus.cfg_div = '0; cfg_bus.cfg_frac = '0;

        do_reset();
        check("rst_tick16", 32'(tick16), 32'd0);
        check("rst_tick1", 32'(tick1), 32'd0);
        check("rst_err", 32'(cfg_bus.cfg_err), 32'd0);
        check("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        check("rst_active", 32'(active_div), 32'd78);

        foreach (vecs[i]) begin
            do_reset();
            if (vecs[i].send) begin
                cfg_send(vecs[i].div, 0, err_seen);
                check("vec_err", 32'(err_seen), 32'(vecs[i].exp_err));
            end
            check("vec_active", 32'(active_div), 32'(vecs[i].exp_act));
            tx_en = !vecs[i].use_rx; rx_en = vecs[i].use_rx;
            step();
            c0 = cyc;
            t16_q.delete(); t1_q.delete();
            run_until(2, 2, vecs[i].exp_p1 * 3 + 200);
            if (t16_q.size() >= 2 && t1_q.size() >= 2) begin
                check("vec_first16", 32'(t16_q[0] - c0), 32'(vecs[i].exp_first));
                check("vec_p16", 32'(t16_q[1] - t16_q[0]), 32'(vecs[i].exp_p16));
                check("vec_first1", 32'(t1_q[0] - c0), 32'(vecs[i].exp_p1));
                check("vec_p1", 32'(t1_q[1] - t1_q[0]), 32'(vecs[i].exp_p1));
            end
        end

        // Mid-bit divisor change 4 -> 8 takes effect on the next bit tick.
        do_reset();
        cfg_send(4, 0, err_seen);
        tx_en = 1;
        t16_q.delete(); t1_q.delete();
        run_until(3, 0, 100);
        cfg_send(8, 0, err_seen);
        check("pend_ready_low", 32'(cfg_bus.cfg_ready), 32'd0);
        check("pend_active_old", 32'(active_div), 32'd4);
        t = 0;
        while (cfg_bus.cfg_ready !== 1'b1 && t < 200) begin step(); t++; end
        check("apply_on_tick1", 32'(tick1), 32'd1);
        check("apply_div", 32'(active_div), 32'd8);
        if (t16_q.size() >= 2) check("old_period", 32'(t16_q[$] - t16_q[$-1]), 32'd4);
        t = cyc; t16_q.delete();
        run_until(1, 0, 50);
        if (t16_q.size() >= 1) check("new_period", 32'(t16_q[0] - t), 32'd8);

        // Illegal divisor while running: one transfer, one error pulse, divisor kept.
        cfg_send(1, 0, err_seen);
        errs = int'(err_seen);
        for (int i = 0; i < 10; i++) begin step(); errs += int'(cfg_bus.cfg_err); end
        check("illegal_err_once", 32'(errs), 32'd1);
        check("illegal_keeps_div", 32'(active_div), 32'd8);

        // rx_restart re-phases: next tick16 after 4 cycles, tick1 after 32.
        do_reset();
        cfg_send(4, 0, err_seen);
        rx_en = 1;
        t16_q.delete(); t1_q.delete();
        run_until(2, 0, 100);
        rx_restart = 1; step(); rx_restart = 0;
        tr = cyc;
        t16_q.delete(); t1_q.delete();
        run_until(1, 1, 200);
        if (t16_q.size() >= 1 && t1_q.size() >= 1) begin
            check("restart_t16", 32'(t16_q[0] - tr), 32'd4);
            check("restart_t1", 32'(t1_q[0] - tr), 32'd32);
        end
        t16_q.delete();
        run_until(1, 0, 50);
        step(); step(); step();
        rx_restart = 1; step(); rx_restart = 0;
        check("restart_on_zero_no_tick", 32'(tick16), 32'd0);
        tr = cyc; t16_q.delete();
        run_until(1, 0, 50);
        if (t16_q.size() >= 1) check("restart_on_zero_next", 32'(t16_q[0] - tr), 32'd4);

`ifdef BAUD_CTRL_FRAC_EN
        do_reset();
        cfg_send(4, 8, err_seen);
        tx_en = 1;
        t16_q.delete(); t1_q.delete();
        run_until(4, 3, 400);
        if (t1_q.size() >= 3 && t16_q.size() >= 4) begin
            check("frac_p1", 32'(t1_q[2] - t1_q[1]), 32'd72);
            check("frac_pair", 32'((t16_q[2] - t16_q[1]) + (t16_q[3] - t16_q[2])), 32'd9);
            check("frac_alt", 32'((t16_q[2] - t16_q[1]) != (t16_q[3] - t16_q[2])), 32'd1);
        end
`endif

        // Reset in mid-bit restores every output on the next cycle.
        rst_n = 0; step(); rst_n = 1;
        check("midrst_tick16", 32'(tick16), 32'd0);
        check("midrst_tick1", 32'(tick1), 32'd0);
        check("midrst_err", 32'(cfg_bus.cfg_err), 32'd0);
        check("midrst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        check("midrst_active", 32'(active_div), 32'd78);

        // Randomized traffic with held-valid handshakes, restarts, enables and resets.
        tx_en = 1; rx_en = 0;
        for (int i = 0; i < 6000; i++) begin
            if (!cfg_bus.cfg_valid && $urandom_range(0, 24) == 0) begin
                cfg_bus.cfg_valid = 1;
                cfg_bus.cfg_div   = DW'($urandom_range(0, 12));
                cfg_bus.cfg_frac  = 4'($urandom_range(0, 15));
            end
            rst_n      = ($urandom_range(0, 1499) != 0);
            rx_restart = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 249) == 0) tx_en = ~tx_en;
            if ($urandom_range(0, 249) == 0) rx_en = ~rx_en;
            step();
            if (last_xfer) begin
                $display("rand xfer div=%0d frac=%0d err=%0b active=%0d cycle=%0d",
                         cfg_bus.cfg_div, cfg_bus.cfg_frac, cfg_bus.cfg_err, active_div, cyc);
                cfg_bus.cfg_valid = 0;
            end
        end
        rst_n = 1; rx_restart = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/baud_ctrl.md
# baud_ctrl

Programmable baud-tick scheduler for the UART. It owns the single baud divisor and produces a 16x oversample tick for the receiver and a 1x bit tick for the transmitter. It also sequences runtime divisor changes so that a new rate takes effect only on a bit boundary. It sits between the host configuration path and the `uart_tx`/`uart_rx` engines, and replaces free-running fixed dividers on the baud path.

## Interface
Parameters:
- `DIV_WIDTH`, default 16: width of the divisor and down-counter.
- `DEFAULT_DIV`, default 78: divisor loaded at reset (12 MHz / (9600 × 16)).

Ports:
- `clk_in`, input, 1: system clock (12 MHz). One clock domain only.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `tx_en`, input, 1: transmitter requests ticks.
- `rx_en`, input, 1: receiver requests ticks.
- `rx_restart`, input, 1: one-cycle pulse from RX start-bit detect; re-phases the ticks.
- `cfg_valid`, input, 1: new divisor offered.
- `cfg_ready`, output, 1: divisor can be accepted.
- `cfg_div`, input, `DIV_WIDTH`: requested divisor, in clocks per tick16.
- `cfg_frac`, input, 4: fractional divisor in sixteenths. Used only with `BAUD_CTRL_FRAC_EN`.
- `cfg_err`, output, 1: one-cycle pulse when an illegal divisor is accepted.
- `active_div`, output, `DIV_WIDTH`: divisor currently in use.
- `tick16`, output, 1: one-cycle oversample tick.
- `tick1`, output, 1: one-cycle bit tick, asserted every 16th `tick16`.

## Operation
- Define `run = tx_en | rx_en`.
- States: IDLE, RUN, PEND.
  - IDLE → RUN when `run` is sampled high.
  - RUN → PEND when a legal divisor is accepted.
  - PEND → RUN on the next `tick1`.
  - RUN or PEND → IDLE when `run` is sampled low.
- Counters: `cnt` (`DIV_WIDTH` bits, down-counter) and `phase` (4 bits).
  - In IDLE: `cnt = 0`, `phase = 0`, and no ticks are produced.
- Handshake:
  - A transfer occurs when `cfg_valid & cfg_ready`.
  - `cfg_ready` is 1 in IDLE and RUN, and 0 in PEND.
  - `cfg_valid` may be held high; it is accepted exactly once per transfer.
- Legality:
  - `cfg_div < 2` is illegal. The transfer still completes, `cfg_err` pulses in the following cycle, and the state and `active_div` are unchanged.
- In IDLE: a legal divisor is written to `active_div` on the accepting edge.
- In RUN: a legal divisor goes to a pending register and the state moves to PEND. On the edge that produces `tick1`, pending is copied to `active_div` and `cnt` reloads from the new value.
- If `run` drops while in PEND, pending is applied immediately and the state goes to IDLE.
- `rx_restart` in RUN or PEND:
  - `cnt` reloads with `active_div - 1` and `phase` is set to 8, so the next `tick1` lands 8 ticks later (mid start bit).
  - If the state is PEND, pending is applied at the restart.
  - `rx_restart` is ignored in IDLE.
- `rx_restart` coincident with `cnt == 0`: the restart wins and no `tick16` is produced that cycle.

## Timing
- Reset values:
  - state IDLE, `cnt = 0`, `phase = 0`.
  - `active_div = DEFAULT_DIV`, pending = `DEFAULT_DIV`.
  - `cfg_ready = 1`, `cfg_err = 0`, `tick16 = 0`, `tick1 = 0`.
- Reset mid-operation aborts any pending change, and all outputs return to their reset values on the next cycle.
- Entering RUN: the edge that samples `run = 1` loads `cnt = active_div - 1`.
- Counting: in RUN, each edge with `cnt == 0` registers `tick16 = 1` and reloads `cnt`; otherwise `cnt` decrements.
  - The first `tick16` is visible `active_div` cycles after entering RUN.
  - The `tick16` period is then `active_div` cycles.
- `phase` increments on each `tick16`. `tick1` is registered on the same edge as the `tick16` whose pre-increment `phase` was 15; `phase` then wraps to 0.
- All outputs are registered. The latency from a `cfg` transfer to `cfg_err` is 1 cycle.

## Configuration
- `BAUD_CTRL_FRAC_EN` defined:
  - `cfg_frac` is captured and applied together with `cfg_div`.
  - A 4-bit accumulator adds `frac` on every `tick16`. When the addition carries, the next tick16 period is `active_div + 1` cycles.
  - Over one `tick1` period the length is exactly `16 × div + frac` cycles.
  - The accumulator clears on reset, on IDLE, on `rx_restart` and on divisor apply.
- `BAUD_CTRL_FRAC_EN` undefined:
  - `cfg_frac` is ignored and every tick16 period is exactly `active_div` cycles.

## Test plan
- Reset, then `tx_en = 1`: `active_div = 78`; first `tick16` at cycle 78; `tick1` at cycle 1248 and every 1248 cycles after.
- In IDLE, `cfg_div = 4` then `rx_en = 1`: `tick16` every 4 cycles; `tick1` every 64 cycles, coincident with every 16th `tick16`.
- In RUN at div 4, `cfg_div = 8` accepted mid-bit:
  - `cfg_ready` is 0 until the next `tick1`.
  - The old 4-cycle period continues up to that `tick1`, then becomes 8 cycles.
  - `active_div` updates on the `tick1` edge.
- `cfg_div = 1` with `cfg_valid` held: exactly one transfer; `cfg_err` pulses once; `active_div` is unchanged; ticks are uninterrupted.
- At div 4, `rx_restart` pulse: the next `tick16` comes 4 cycles later and `tick1` 32 cycles after the restart. Restart coincident with `cnt == 0` produces no `tick16` that cycle.
- `BAUD_CTRL_FRAC_EN`, div 4, frac 8: `tick1` period is 72 cycles, with tick16 periods alternating 4 and 5. Reset asserted mid-bit: all outputs are 0 and `active_div` is 78 the next cycle.
